arbiter_bus_mux: RTL

Downstream stage of the 3-way round-robin arbiter (arbiter_rr). It consumes gnt0..gnt2 and runs exactly one register-bus transaction on the shared bus for the granted requester. It routes that requester's address, write data and direction onto the bus, and returns read data plus a one-cycle ack (with error flag) to the requester. A watchdog guarantees a stalled bus slave cannot deadlock the arbiter.

---
 rtl/arbiter_bus_mux.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/arbiter_bus_mux.sv
// Bus-side stage behind the 3-way round-robin arbiter: runs one register-bus
// transaction per grant, returns ack/err/rdata, and times out a stalled slave.
module arbiter_bus_mux #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          gnt2,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    input  logic          we0,
    input  logic          we1,
    input  logic          we2,
    output logic          ack0,
    output logic          ack1,
    output logic          ack2,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          gnt_conflict,
    output logic          bus_cyc,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, HOLD} state_t;

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    ack_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic          conflict_q;
    logic          bus_cyc_q;
    logic          bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;

    logic [2:0]    gnt_v;
    logic [1:0]    idx_d;
    logic          multi_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          we_d;

    assign gnt_v   = {gnt2, gnt1, gnt0};
    assign multi_d = (gnt0 & gnt1) | (gnt0 & gnt2) | (gnt1 & gnt2);

    // Lowest set grant wins if the arbiter ever hands out more than one.
    always_comb begin
        idx_d   = 2'd0;
        addr_d  = addr0;
        wdata_d = wdata0;
        we_d    = we0;
        if (!gnt0 && gnt1) begin
            idx_d   = 2'd1;
            addr_d  = addr1;
            wdata_d = wdata1;
            we_d    = we1;
        end else if (!gnt0 && !gnt1 && gnt2) begin
            idx_d   = 2'd2;
            addr_d  = addr2;
            wdata_d = wdata2;
            we_d    = we2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            ack_q       <= 3'b000;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            conflict_q  <= 1'b0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt_v) begin
                        idx_q       <= idx_d;
                        bus_addr_q  <= addr_d;
                        bus_wdata_q <= wdata_d;
                        bus_we_q    <= we_d;
                        bus_cyc_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ACTIVE;
                        if (multi_d) conflict_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A slave ack on the timeout edge still counts as success.
                    if (bus_ack) begin
                        bus_cyc_q <= 1'b0;
                        if (!bus_we_q) rdata_q <= bus_rdata;
                        ack_q     <= 3'b001 << idx_q;
                        err_q     <= 1'b0;
                        state_q   <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        bus_cyc_q <= 1'b0;
                        ack_q     <= 3'b001 << idx_q;
                        err_q     <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    ack_q   <= 3'b000;
                    err_q   <= 1'b0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    // One transfer per grant: wait for the grant to drop.
                    if (!gnt_v[idx_q]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0         = ack_q[0];
    assign ack1         = ack_q[1];
    assign ack2         = ack_q[2];
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign gnt_conflict = conflict_q;
    assign bus_cyc      = bus_cyc_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;

endmodule
